// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches an 8-word block through the arbiter
// request/service handshake and steers returned words into the data array.
module cache_fill_fsm #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              service,
  input  logic [ADDR_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_request,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [2:0]        word_offset,
  output logic [ADDR_W-1:0] fill_data,
  output logic              fill_done
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [3:0] LastWord = 4'(WORDS_PER_BLOCK - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-5:0] blk_addr_q, blk_addr_d;
  logic [3:0]        issue_cnt_q, issue_cnt_d;
  logic [3:0]        recv_cnt_q, recv_cnt_d;
  logic [3:0]        outstanding;
  logic              grant, accept, last_recv;
  logic              unused_offset_bits;

  // The byte offset within the block is irrelevant; the whole block is fetched.
  assign unused_offset_bits = ^miss_address[3:0];

  assign outstanding = issue_cnt_q - recv_cnt_q;
  assign grant       = (state_q == StIssue) && service;
  // Valids with nothing outstanding (stale data after reset, strays) are dropped.
  assign accept      = (state_q != StIdle) && memory_data_valid && (outstanding != 4'd0);
  assign last_recv   = accept && (recv_cnt_q == LastWord);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      blk_addr_q  <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      blk_addr_q  <= blk_addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    blk_addr_d  = blk_addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      StIdle: begin
        if (miss_detected) begin
          state_d     = StIssue;
          blk_addr_d  = miss_address[ADDR_W-1:4];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      StIssue: begin
        if (grant) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
          if (issue_cnt_q == LastWord) state_d = StWait;
        end
      end
      StWait: begin
        if (last_recv) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) recv_cnt_d = recv_cnt_q + 4'd1;
  end

  always_comb begin
    fsm_busy         = (state_q != StIdle);
    mem_request      = (state_q == StIssue);
    memory_address   = '0;
    write_data_array = accept;
    word_offset      = accept ? recv_cnt_q[2:0] : 3'd0;
    write_tag_array  = last_recv;
    fill_done        = last_recv;
    fill_data        = memory_data;
    case (state_q)
      StIssue: memory_address = {blk_addr_q, issue_cnt_q[2:0], 1'b0};
      // Hold the last issued word address while draining responses.
      StWait:  memory_address = {blk_addr_q, LastWord[2:0], 1'b0};
      default: memory_address = '0;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: fixed-latency memory model feeding a
// scoreboard of expected array writes, plus a per-cycle table for the basic fill.
module tb_cache_fill_fsm;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst, miss_detected, service, memory_data_valid;
  logic [15:0] miss_address, memory_data;
  logic        fsm_busy, mem_request, write_data_array, write_tag_array, fill_done;
  logic [15:0] memory_address, fill_data;
  logic [2:0]  word_offset;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .service           (service),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_request       (mem_request),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .word_offset       (word_offset),
    .fill_data         (fill_data),
    .fill_done         (fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [15:0] addr; bit live;} resp_t;
  typedef struct {logic [2:0] off; logic [15:0] data;} exp_t;
  typedef struct {logic miss; logic busy; logic req; logic [15:0] addr; logic done;} vec_t;

  resp_t       pend[$];
  exp_t        sb[$];
  vec_t        tbl[14];
  int          passed = 0, total = 0, cyc = 0;
  int          g_idx, grants, writes;
  logic [11:0] blk_exp;
  bit          dl, done_exp, done_seen, granted, cur_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'hB5C3;
  endfunction

  task automatic begin_fill(input logic [15:0] a);
    blk_exp = a[15:4]; g_idx = 0; grants = 0; done_seen = 0;
  endtask

  // Drive one cycle's inputs; the memory model answers each grant L cycles later.
  task automatic drive(input logic miss, input logic [15:0] a, input logic svc,
                       input logic do_rst, input logic stray);
    exp_t e;
    rst = do_rst; miss_detected = miss; miss_address = a; service = svc; cur_rst = do_rst;
    dl = 0; done_exp = 0;
    if (do_rst) foreach (pend[i]) pend[i].live = 0;
    if (!do_rst && pend.size() > 0 && pend[0].due <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = word_of(pend[0].addr);
      if (pend[0].live) begin
        e.off = pend[0].addr[3:1]; e.data = memory_data;
        sb.push_back(e);
        dl = 1; done_exp = (e.off == 3'd7);
      end
      void'(pend.pop_front());
    end else begin
      memory_data_valid = stray && !do_rst;
      memory_data       = 16'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic sample();
    exp_t e;
    granted = 0;
    check("fill_data", fill_data, memory_data);
    if (mem_request) check("req_addr", memory_address, {blk_exp, g_idx[2:0], 1'b0});
    if (mem_request && service) begin
      pend.push_back('{due: cyc + L, addr: {blk_exp, g_idx[2:0], 1'b0}, live: !cur_rst});
      g_idx++; grants++; granted = 1;
    end
    check("write_strobe", write_data_array, dl);
    if (write_data_array) begin
      writes++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("word_offset", word_offset, e.off);
        check("word_data", fill_data, e.data);
      end
    end
    sb.delete();
    check("fill_done", fill_done, done_exp);
    check("write_tag", write_tag_array, done_exp);
    if (fill_done) done_seen = 1;
  endtask

  task automatic adv();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic step(input logic miss, input logic [15:0] a, input logic svc,
                      input logic do_rst, input logic stray);
    drive(miss, a, svc, do_rst, stray); sample(); adv();
  endtask

  // One complete fill from an IDLE start cycle; optional early miss drop,
  // arbiter stalls, and stray valids before the first grant.
  task automatic run_fill(input logic [15:0] a, input int drop_at, input bit stall,
                          input int stray_n);
    int   hold = 0;
    logic svc, str;
    begin_fill(a);
    for (int i = 0; i < 300 && !done_seen; i++) begin
      str = (i >= 1 && i <= stray_n);
      svc = str ? 1'b0 : (stall ? (hold == 0) : 1'b1);
      drive((drop_at < 0 || i <= drop_at), a, svc, 1'b0, str);
      sample();
      if (i == 0) check("start_busy", fsm_busy, 0);
      if (i == 1) check("start_req", mem_request, 1);
      adv();
      if (granted) hold = 3;
      else if (hold > 0) hold--;
    end
    check("fill_done_seen", done_seen, 1);
    check("grant_count", grants, 8);
    check("pend_empty", pend.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && fill_done && mem_request) begin
      total++;
      $display("FAIL protocol: fill_done while still issuing at cycle %0d", cyc);
    end
  end

  initial begin
    for (int c = 0; c < 14; c++) begin
      tbl[c].miss = (c <= 12);
      tbl[c].busy = (c >= 1 && c <= 12);
      tbl[c].req  = (c >= 1 && c <= 8);
      tbl[c].addr = (c == 0 || c == 13) ? 16'h0000 :
                    (c <= 8) ? 16'h1230 + 16'(2 * (c - 1)) : 16'h123E;
      tbl[c].done = (c == 12);
    end

    rst = 1; miss_detected = 0; miss_address = 0; service = 0;
    memory_data_valid = 0; memory_data = 0; writes = 0; blk_exp = 0; g_idx = 0;
    @(posedge clk); #1;

    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0); sample();
    check("rst_busy", fsm_busy, 0);
    check("rst_req", mem_request, 0);
    check("rst_addr", memory_address, 0);
    check("rst_offset", word_offset, 0);
    adv();

    // Basic fill, service tied high, L = 4.
    begin_fill(16'h1236);
    cyc = 0;
    for (int c = 0; c < 14; c++) begin
      drive(tbl[c].miss, 16'h1236, 1'b1, 1'b0, 1'b0);
      sample();
      check("tbl_busy", fsm_busy, tbl[c].busy);
      check("tbl_req", mem_request, tbl[c].req);
      check("tbl_addr", memory_address, tbl[c].addr);
      check("tbl_done", fill_done, tbl[c].done);
      check("tbl_tag", write_tag_array, tbl[c].done);
      adv();
    end

    // Stray valids in IDLE, then in ISSUE before the first grant.
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    run_fill(16'h2468, -1, 1'b0, 2);

    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    run_fill(16'hABCD, -1, 1'b1, 0);

    // Miss dropped after cycle 2, then immediate re-miss at 0x4000.
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    run_fill(16'h3332, 2, 1'b0, 0);
    run_fill(16'h4000, -1, 1'b0, 0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("idle_after_b2b", fsm_busy, 0);

    // Reset after three words land; remaining responses must be ignored.
    begin_fill(16'h5556);
    writes = 0;
    for (int i = 0; i < 20 && writes < 3; i++) step(1'b1, 16'h5556, 1'b1, 1'b0, 1'b0);
    check("three_words", writes, 3);
    step(1'b0, 16'h5556, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 16'h5556, 1'b1, 1'b0, 1'b0); sample();
    check("mid_rst_busy", fsm_busy, 0);
    check("mid_rst_req", mem_request, 0);
    check("mid_rst_addr", memory_address, 0);
    check("mid_rst_wda", write_data_array, 0);
    check("mid_rst_offset", word_offset, 0);
    adv();
    writes = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("no_write_after_rst", writes, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
